// File: rtl/allpass_param_sequencer.sv
// Shadow/commit controller for a bank of allpass stages: writes land in shadow
// registers, a commit applies them on a sample boundary and gains then ramp to target.
module allpass_param_sequencer #(
  parameter int N_FILTERS   = 4,
  parameter int WIDTH       = 24,
  parameter int FIXED_POINT = 8,
  parameter int MAXLEN      = 8192,
  parameter int RAMP_SHIFT  = 2,
  localparam int W          = WIDTH + FIXED_POINT,
  localparam int IDX_W      = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sample_tick,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [W-1:0]           wr_tau,
  input  logic [W-1:0]           wr_gain,
  input  logic                   commit,
  output logic                   busy,
  output logic                   cfg_error,
  output logic [N_FILTERS*W-1:0] tau_out,
  output logic [N_FILTERS*W-1:0] gain_out
);

  typedef enum logic [1:0] {IDLE, ARMED, APPLY, RAMP} state_e;

  localparam logic signed [W-1:0] TAU_RST  = W'(4096);
  localparam logic signed [W-1:0] TAU_MIN  = W'(1);
  localparam logic signed [W-1:0] TAU_MAX  = W'(MAXLEN - 1);
  localparam logic signed [W-1:0] GAIN_MAX = W'(255);
  localparam logic signed [W-1:0] GAIN_MIN = W'(-255);
  localparam logic signed [W:0]   STEP_HI  = (W+1)'(1 << RAMP_SHIFT);
  localparam logic signed [W:0]   STEP_LO  = (W+1)'(-(1 << RAMP_SHIFT));

  state_e state_q, state_d;
  logic   pending_q, pending_d, pend_now;
  logic   busy_q, busy_d;
  logic   wr_ready_q, wr_ready_d;
  logic   cfg_error_q, cfg_error_d;

  logic signed [W-1:0] tau_sh_q   [N_FILTERS];
  logic signed [W-1:0] tau_sh_d   [N_FILTERS];
  logic signed [W-1:0] gain_sh_q  [N_FILTERS];
  logic signed [W-1:0] gain_sh_d  [N_FILTERS];
  logic signed [W-1:0] target_q   [N_FILTERS];
  logic signed [W-1:0] target_d   [N_FILTERS];
  logic signed [W-1:0] tau_act_q  [N_FILTERS];
  logic signed [W-1:0] tau_act_d  [N_FILTERS];
  logic signed [W-1:0] gain_act_q [N_FILTERS];
  logic signed [W-1:0] gain_act_d [N_FILTERS];
  logic signed [W-1:0] ramp_val   [N_FILTERS];
  logic signed [W:0]   diff       [N_FILTERS];
  logic signed [W:0]   step       [N_FILTERS];

  logic                all_settled;
  logic                wr_accept, idx_ok, tau_clip, gain_clip;
  logic signed [W-1:0] tau_in, gain_in, tau_sat, gain_sat;

  always_comb begin
    tau_in    = $signed(wr_tau);
    gain_in   = $signed(wr_gain);
    tau_sat   = tau_in;
    tau_clip  = 1'b0;
    gain_sat  = gain_in;
    gain_clip = 1'b0;
    if (tau_in < TAU_MIN) begin
      tau_sat  = TAU_MIN;
      tau_clip = 1'b1;
    end else if (tau_in > TAU_MAX) begin
      tau_sat  = TAU_MAX;
      tau_clip = 1'b1;
    end
    if (gain_in < GAIN_MIN) begin
      gain_sat  = GAIN_MIN;
      gain_clip = 1'b1;
    end else if (gain_in > GAIN_MAX) begin
      gain_sat  = GAIN_MAX;
      gain_clip = 1'b1;
    end
    idx_ok    = int'(wr_idx) < N_FILTERS;
    wr_accept = wr_valid & wr_ready_q;
  end

  // Difference is one bit wider than the word so target - gain never wraps.
  always_comb begin
    all_settled = 1'b1;
    for (int i = 0; i < N_FILTERS; i++) begin
      diff[i] = {target_q[i][W-1], target_q[i]} - {gain_act_q[i][W-1], gain_act_q[i]};
      step[i] = diff[i] >>> RAMP_SHIFT;
      if (diff[i] > STEP_LO && diff[i] < STEP_HI) begin
        ramp_val[i] = target_q[i];
      end else begin
        ramp_val[i] = gain_act_q[i] + step[i][W-1:0];
      end
      if (ramp_val[i] != target_q[i]) begin
        all_settled = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_now  = pending_q | (commit & ((state_q == APPLY) | (state_q == RAMP)));
    pending_d = pend_now;
    case (state_q)
      IDLE:  if (commit) state_d = ARMED;
      ARMED: if (sample_tick) state_d = APPLY;
      APPLY: state_d = RAMP;
      RAMP: begin
        if (sample_tick && all_settled) begin
          state_d   = pend_now ? ARMED : IDLE;
          pending_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tau_sh_d    = tau_sh_q;
    gain_sh_d   = gain_sh_q;
    target_d    = target_q;
    tau_act_d   = tau_act_q;
    gain_act_d  = gain_act_q;
    cfg_error_d = wr_accept & (~idx_ok | tau_clip | gain_clip);
    if (wr_accept && idx_ok) begin
      tau_sh_d[wr_idx]  = tau_sat;
      gain_sh_d[wr_idx] = gain_sat;
    end
    if (state_q == APPLY) begin
      tau_act_d = tau_sh_q;
      target_d  = gain_sh_q;
    end
    if (state_q == RAMP && sample_tick) begin
      gain_act_d = ramp_val;
    end
    busy_d     = (state_d != IDLE) | pending_d;
    wr_ready_d = (state_d != APPLY);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_FILTERS; i++) begin
        tau_sh_q[i]   <= TAU_RST;
        gain_sh_q[i]  <= '0;
        target_q[i]   <= '0;
        tau_act_q[i]  <= TAU_RST;
        gain_act_q[i] <= '0;
      end
      busy_q      <= 1'b0;
      wr_ready_q  <= 1'b1;
      cfg_error_q <= 1'b0;
    end else begin
      tau_sh_q    <= tau_sh_d;
      gain_sh_q   <= gain_sh_d;
      target_q    <= target_d;
      tau_act_q   <= tau_act_d;
      gain_act_q  <= gain_act_d;
      busy_q      <= busy_d;
      wr_ready_q  <= wr_ready_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  always_comb begin
    tau_out  = '0;
    gain_out = '0;
    for (int i = 0; i < N_FILTERS; i++) begin
      tau_out[i*W +: W]  = tau_act_q[i];
      gain_out[i*W +: W] = gain_act_q[i];
    end
  end

  assign busy      = busy_q;
  assign wr_ready  = wr_ready_q;
  assign cfg_error = cfg_error_q;

endmodule

// File: tb/tb_allpass_param_sequencer.sv
// Scoreboard bench: every change of the visible outputs is an event matched in
// order against hand-computed snapshots queued by the stimulus.
module tb_allpass_param_sequencer;

  // Five stages so that an out-of-range index such as 5 is encodable on wr_idx.
  localparam int N     = 5;
  localparam int W     = 32;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             sample_tick = 1'b0;
  logic             wr_valid = 1'b0;
  logic             commit = 1'b0;
  logic [IDX_W-1:0] wr_idx = '0;
  logic [W-1:0]     wr_tau = '0;
  logic [W-1:0]     wr_gain = '0;
  logic             wr_ready, busy, cfg_error;
  logic [N*W-1:0]   tau_out, gain_out;

  allpass_param_sequencer #(
    .N_FILTERS(N), .WIDTH(24), .FIXED_POINT(8), .MAXLEN(8192), .RAMP_SHIFT(2)
  ) dut (
    .clk(clk), .rstn(rstn), .sample_tick(sample_tick),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_tau(wr_tau), .wr_gain(wr_gain), .commit(commit),
    .busy(busy), .cfg_error(cfg_error), .tau_out(tau_out), .gain_out(gain_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*W-1:0] tau;
    logic [N*W-1:0] gain;
    logic           busy;
    logic           ready;
    logic           err;
  } snap_t;

  snap_t          exp_q[$];
  snap_t          prev_snap;
  bit             mon_en = 1'b0;
  int             checks = 0;
  int             errors = 0;
  logic [N*W-1:0] e_tau, e_gain, e_sh_tau;
  logic           e_busy, e_ready;
  int             seq[$];

  function automatic snap_t sampleDut();
    return '{tau: tau_out, gain: gain_out, busy: busy, ready: wr_ready, err: cfg_error};
  endfunction

  task automatic checkOutput(input string name, input logic [$bits(snap_t)-1:0] act,
                             input logic [$bits(snap_t)-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    snap_t cur;
    if (mon_en) begin
      cur = sampleDut();
      if (cur !== prev_snap) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event actual=%h required=none", cur);
        end else begin
          checkOutput("output_event", cur, exp_q.pop_front());
        end
      end
      prev_snap = cur;
    end
  end

  task automatic pushExp(input logic err);
    exp_q.push_back('{tau: e_tau, gain: e_gain, busy: e_busy, ready: e_ready, err: err});
  endtask

  task automatic setGain(input int s, input int v);
    e_gain[s*W +: W] = v;
  endtask

  task automatic setShadowTau(input int s, input int v);
    e_sh_tau[s*W +: W] = v;
  endtask

  task automatic applyStimulus(input logic c, input logic t, input logic v,
                               input int idx, input int tau, input int gain);
    commit      = c;
    sample_tick = t;
    wr_valid    = v;
    wr_idx      = idx[IDX_W-1:0];
    wr_tau      = tau;
    wr_gain     = gain;
    @(posedge clk);
    #1;
    commit      = 1'b0;
    sample_tick = 1'b0;
    wr_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic errWrite(input int idx, input int tau, input int gain);
    pushExp(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, idx, tau, gain);
    pushExp(1'b0);
    idle(1);
  endtask

  // Commit, prove ARMED holds without a tick, tick into APPLY, then leave APPLY.
  task automatic commitApply(input bit wr_in_apply, input bit tick_with_commit);
    e_busy = 1'b1;
    pushExp(1'b0);
    applyStimulus(1'b1, tick_with_commit, 1'b0, 0, 0, 0);
    idle(2);
    e_ready = 1'b0;
    pushExp(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    e_ready = 1'b1;
    e_tau   = e_sh_tau;
    pushExp(1'b0);
    if (wr_in_apply) applyStimulus(1'b0, 1'b0, 1'b1, 1, 555, 0);
    else             idle(1);
  endtask

  task automatic runRamp(input int s, input bit finishes, input logic end_busy, input int gap);
    foreach (seq[i]) begin
      setGain(s, seq[i]);
      if (finishes && i == seq.size() - 1) e_busy = end_busy;
      pushExp(1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
      idle(gap);
    end
  endtask

  task automatic finishNoGain();
    e_busy = 1'b0;
    pushExp(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(2);
  endtask

  task automatic resetExpect();
    e_tau    = {N{32'd4096}};
    e_sh_tau = {N{32'd4096}};
    e_gain   = '0;
    e_busy   = 1'b0;
    e_ready  = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tau"}, tau_out, {N{32'd4096}});
    checkOutput({tag, "_gain"}, gain_out, '0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_ready"}, wr_ready, 1'b1);
    checkOutput({tag, "_err"}, cfg_error, 1'b0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetExpect();
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rstn      = 1'b1;
    prev_snap = sampleDut();
    mon_en    = 1'b1;
    idle(2);

    $display("[TB] tau apply on stage 1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 1000, 0);
    setShadowTau(1, 1000);
    commitApply(1'b0, 1'b0);
    finishNoGain();

    $display("[TB] gain ramp 0 -> 128, write attempted during APPLY");
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 4096, 128);
    commitApply(1'b1, 1'b0);
    seq = '{32, 56, 74, 87, 97, 104, 110, 114, 117, 119, 121, 122, 123, 124, 125, 128};
    runRamp(0, 1'b1, 1'b0, 1);
    idle(2);

    $display("[TB] negative ramp 128 -> -128 with back-to-back ticks");
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 4096, -128);
    commitApply(1'b0, 1'b0);
    seq = '{64, 16, -20, -47, -68, -83, -95, -104, -110, -115, -119, -122, -124, -125, -128};
    runRamp(0, 1'b1, 1'b0, 0);
    idle(2);

    $display("[TB] clamping and dropped writes");
    errWrite(2, 0, 0);
    setShadowTau(2, 1);
    errWrite(3, 100, 300);
    setShadowTau(3, 100);
    errWrite(5, 77, 77);
    errWrite(4, 20000, 0);
    setShadowTau(4, 8191);
    commitApply(1'b0, 1'b0);
    seq = '{63, 111, 147, 174, 194, 209, 220, 228, 234, 239, 243, 246, 248, 249, 250, 251, 252, 255};
    runRamp(3, 1'b1, 1'b0, 1);
    idle(2);

    $display("[TB] commit during RAMP with a new shadow gain");
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 1000, 8);
    commitApply(1'b0, 1'b0);
    seq = '{2};
    runRamp(1, 1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1, 1000, 0);
    seq = '{3, 4, 5, 8};
    runRamp(1, 1'b1, 1'b1, 0);
    idle(3);
    e_ready = 1'b0;
    pushExp(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    e_ready = 1'b1;
    pushExp(1'b0);
    idle(1);
    seq = '{6, 4, 3, 0};
    runRamp(1, 1'b1, 1'b0, 1);
    idle(2);

    $display("[TB] commit coincident with sample_tick in IDLE");
    applyStimulus(1'b0, 1'b0, 1'b1, 2, 2000, 0);
    setShadowTau(2, 2000);
    commitApply(1'b0, 1'b1);
    finishNoGain();

    $display("[TB] reset asserted mid-ramp");
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 4096, 128);
    commitApply(1'b0, 1'b0);
    seq = '{-64, -16};
    runRamp(0, 1'b0, 1'b1, 0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checkResetValues("midramp_reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    resetExpect();
    prev_snap = sampleDut();
    mon_en    = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 3, 300, 0);
    setShadowTau(3, 300);
    commitApply(1'b0, 1'b0);
    finishNoGain();

    idle(3);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
